switch_control: RTL and testbench

- Per-router switch allocator for the Phoenix-style XY-routed mesh.
- Sits between the five input buffers and the crossbar. It picks one pending header by round-robin and computes its output port with the XY rule.
- If that output port is free, it acknowledges the header and programs the crossbar tables.
- It releases a connection when the owning input buffer stops sending.

---
 rtl/switch_control.sv | 172 +++++++++++++++++
 tb/tb_switch_control.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_control.sv
// Switch allocator for one XY-routed mesh router: round-robin header selection,
// XY output computation, crossbar table programming and connection release.

`ifndef EAST
`define EAST 0
`endif
`ifndef WEST
`define WEST 1
`endif
`ifndef NORTH
`define NORTH 2
`endif
`ifndef SOUTH
`define SOUTH 3
`endif
`ifndef LOCAL
`define LOCAL 4
`endif
`ifndef NPORT
`define NPORT 5
`endif
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef METADEFLIT
`define METADEFLIT 8
`endif

module switch_control #(
  parameter logic [`TAM_FLIT-1:0] address = 16'h0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [`NPORT-1:0]             h,
  input  logic [`NPORT*`TAM_FLIT-1:0]   data_in,
  input  logic [`NPORT-1:0]             sender,
  output logic [`NPORT-1:0]             ack_h,
  output logic [`NPORT-1:0]             free,
  output logic [`NPORT*3-1:0]           mux_in,
  output logic [`NPORT*3-1:0]           mux_out
);

  localparam int NPORT    = `NPORT;
  localparam int TAM_FLIT = `TAM_FLIT;
  localparam int HALF     = `METADEFLIT;

  typedef logic [2:0] port_t;
  typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_t;

  localparam port_t P_EAST  = port_t'(`EAST);
  localparam port_t P_WEST  = port_t'(`WEST);
  localparam port_t P_NORTH = port_t'(`NORTH);
  localparam port_t P_SOUTH = port_t'(`SOUTH);
  localparam port_t P_LOCAL = port_t'(`LOCAL);

  localparam logic [HALF-1:0] LX = address[TAM_FLIT-1:HALF];
  localparam logic [HALF-1:0] LY = address[HALF-1:0];

  state_t state, state_nx;
  port_t  sel, out, last;
  port_t  mux_in_q  [NPORT];
  port_t  mux_out_q [NPORT];

  logic [TAM_FLIT-1:0] flit [NPORT];
  logic [TAM_FLIT-1:0] hdr_sel;
  port_t               route_dir;
  port_t               arb_pick;
  logic                arb_found;
  int                  idx;
  logic                grant_ok;
  logic                grant_busy;

  // XY dimension-order routing: resolve X first, then Y, else deliver locally.
  function automatic port_t xy_route(input logic [TAM_FLIT-1:0] hdr);
    logic [HALF-1:0] dx, dy;
    port_t           dir;
    dx = hdr[TAM_FLIT-1:HALF];
    dy = hdr[HALF-1:0];
    if (dx > LX)      dir = P_EAST;
    else if (dx < LX) dir = P_WEST;
    else if (dy < LY) dir = P_SOUTH;
    else if (dy > LY) dir = P_NORTH;
    else              dir = P_LOCAL;
    return dir;
  endfunction

  for (genvar g = 0; g < NPORT; g++) begin : g_unpack
    assign flit[g]             = data_in[g*TAM_FLIT +: TAM_FLIT];
    assign mux_in[g*3 +: 3]    = mux_in_q[g];
    assign mux_out[g*3 +: 3]   = mux_out_q[g];
  end

  assign hdr_sel   = flit[sel];
  assign route_dir = xy_route(hdr_sel);

  // Round-robin search starting one past the last port served.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch so no latch is inferred.
    arb_pick  = last;
    arb_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = (int'(last) + k) % NPORT;
      if (!arb_found && h[idx]) begin
        arb_pick  = port_t'(idx);
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_ok   = 1'b0;
    grant_busy = 1'b0;
    unique case (state)
      IDLE:  if (|h) state_nx = ARB;
      ARB:   state_nx = arb_found ? ROUTE : IDLE;
      ROUTE: state_nx = GRANT;
      GRANT: begin
        state_nx   = IDLE;
        grant_ok   = h[sel] &&  free[out];
        grant_busy = h[sel] && !free[out];
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_h <= '0;
      free  <= '1;
      sel   <= '0;
      out   <= '0;
      last  <= P_LOCAL;
      // NOTE: the crossbar tables are a handful of flops driving outputs, so they are reset like any other state.
      for (int i = 0; i < NPORT; i++) begin
        mux_in_q[i]  <= '0;
        mux_out_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let release and grant both read the pre-edge free vector.
      ack_h <= '0;

      if (state == ARB && arb_found) sel <= arb_pick;
      if (state == ROUTE)            out <= route_dir;

      // Release runs every cycle; table entries are left stale once free.
      for (int o = 0; o < NPORT; o++) begin
        if (!free[o] && !sender[mux_in_q[o]]) free[o] <= 1'b1;
      end

      if (grant_ok) begin
        ack_h[sel]     <= 1'b1;
        free[out]      <= 1'b0;
        mux_in_q[out]  <= sel;
        mux_out_q[sel] <= out;
        last           <= sel;
      end else if (grant_busy) begin
        last <= sel;
      end
    end
  end

  a_ack_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(ack_h));
  a_ack_pulse:  assert property (@(posedge clock) disable iff (reset) (|ack_h) |=> !(|ack_h));

endmodule

// File: tb/tb_switch_control.sv
// Scoreboard bench for switch_control: expected grants are queued at request
// time and matched against each ack_h pulse, sampled on the falling edge.

`ifndef EAST
`define EAST 0
`endif
`ifndef WEST
`define WEST 1
`endif
`ifndef NORTH
`define NORTH 2
`endif
`ifndef SOUTH
`define SOUTH 3
`endif
`ifndef LOCAL
`define LOCAL 4
`endif

module tb_switch_control;

  localparam logic [15:0] ADDR = 16'h0101;

  logic        clock;
  logic        reset;
  logic [4:0]  h;
  logic [79:0] data_in;
  logic [4:0]  sender;
  logic [4:0]  ack_h;
  logic [4:0]  free;
  logic [14:0] mux_in;
  logic [14:0] mux_out;

  switch_control #(.address(ADDR)) dut (
    .clock   (clock),
    .reset   (reset),
    .h       (h),
    .data_in (data_in),
    .sender  (sender),
    .ack_h   (ack_h),
    .free    (free),
    .mux_in  (mux_in),
    .mux_out (mux_out)
  );

  typedef struct {
    int src;
    int dst;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  int         tests_run;
  int         tests_failed;
  int         ack_count;
  int         cycle;
  logic [4:0] prev_ack;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cycle = 0;
    forever begin
      @(posedge clock);
      cycle++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no summary, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // Falling-edge monitor: matches each ack pulse to the oldest expected grant
  // and models the input buffer dropping h once acknowledged.
  task automatic monitor_step();
    exp_t e;
    if (reset) begin
      prev_ack = '0;
    end else if (prev_ack != 0) begin
      check("ack_one_cycle", ack_h, 0);
      prev_ack = ack_h;
    end else if (ack_h != 0) begin
      ack_count++;
      prev_ack = ack_h;
      if (sb.size() == 0) begin
        check("unexpected_ack", ack_h, 0);
      end else begin
        e = sb.pop_front();
        check("ack_src",    ack_h, 32'(1) << e.src);
        check("mux_out",    mux_out[e.src*3 +: 3], e.dst);
        check("mux_in",     mux_in[e.dst*3 +: 3], e.src);
        check("free_taken", free[e.dst], 0);
        if (e.cyc >= 0) check("grant_cycle", cycle, e.cyc);
        h[e.src] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor_step();
    @(posedge clock);
    #2;
  endtask

  // dst < 0 means no grant is expected; lat < 0 means grant time is not checked.
  task automatic request(input int src, input logic [15:0] hdr, input int dst, input int lat);
    exp_t e;
    data_in[src*16 +: 16] = hdr;
    h[src] = 1'b1;
    if (dst >= 0) begin
      e.src = src;
      e.dst = dst;
      e.cyc = (lat < 0) ? -1 : cycle + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    h       = '0;
    sender  = '0;
    data_in = '0;
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  logic [15:0] xy_hdr [4];
  int          xy_dst [4];
  logic [15:0] fair_hdr [5];
  int          fair_dst [5];
  int          base;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ack_count    = 0;
    prev_ack     = '0;
    reset        = 1'b1;
    h            = '0;
    sender       = '0;
    data_in      = '0;

    xy_hdr = '{16'h0001, 16'h0100, 16'h0105, 16'h0101};
    xy_dst = '{`WEST, `SOUTH, `NORTH, `LOCAL};
    fair_hdr[`EAST]  = 16'h0001;  fair_dst[`EAST]  = `WEST;
    fair_hdr[`WEST]  = 16'h0301;  fair_dst[`WEST]  = `EAST;
    fair_hdr[`NORTH] = 16'h0100;  fair_dst[`NORTH] = `SOUTH;
    fair_hdr[`SOUTH] = 16'h0105;  fair_dst[`SOUTH] = `NORTH;
    fair_hdr[`LOCAL] = 16'h0101;  fair_dst[`LOCAL] = `LOCAL;

    do_reset();
    check("rst_ack_h",   ack_h,   0);
    check("rst_free",    free,    5'b11111);
    check("rst_mux_in",  mux_in,  0);
    check("rst_mux_out", mux_out, 0);

    // Single route LOCAL -> EAST, connection held by sender.
    sender[`LOCAL] = 1'b1;
    request(`LOCAL, 16'h0301, `EAST, 4);
    wait_drain(10);
    tick();
    check("single_free_held", free, 5'b11110);

    // Reset while a second request sits in GRANT.
    request(`WEST, 16'h0001, -1, -1);
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    check("midrst_ack_h",   ack_h,   0);
    check("midrst_free",    free,    5'b11111);
    check("midrst_mux_in",  mux_in,  0);
    check("midrst_mux_out", mux_out, 0);
    tick();
    reset  = 1'b0;
    sender = '0;
    begin
      exp_t e;
      e.src = `WEST;
      e.dst = `WEST;
      e.cyc = cycle + 4;
      sb.push_back(e);
    end
    wait_drain(10);

    // XY rule from LOCAL; connections release at once with sender low.
    for (int i = 0; i < 4; i++) begin
      tick();
      request(`LOCAL, xy_hdr[i], xy_dst[i], 4);
      wait_drain(10);
      repeat (2) tick();
      check("xy_released", free, 5'b11111);
    end

    // Fairness: all five request at once, served in port order 4 cycles apart.
    do_reset();
    sender = 5'b11111;
    for (int i = 0; i < 5; i++) request(i, fair_hdr[i], fair_dst[i], 4 * (i + 1));
    wait_drain(30);
    check("fair_all_busy", free, 5'b00000);
    sender = '0;
    repeat (2) tick();
    check("fair_released", free, 5'b11111);

    // Contention: WEST and NORTH both want EAST.
    do_reset();
    sender[`WEST]  = 1'b1;
    sender[`NORTH] = 1'b1;
    request(`WEST,  16'h0301, `EAST, 4);
    request(`NORTH, 16'h0301, -1, -1);
    wait_drain(10);
    base = ack_count;
    repeat (12) tick();
    check("north_refused", ack_count, base);
    check("east_still_busy", free[`EAST], 0);
    begin
      exp_t e;
      e.src = `NORTH;
      e.dst = `EAST;
      e.cyc = -1;
      sb.push_back(e);
    end
    sender[`WEST] = 1'b0;
    wait_drain(40);
    sender[`NORTH] = 1'b0;
    repeat (3) tick();
    check("contention_released", free, 5'b11111);

    // Withdrawn request: h[SOUTH] held for two cycles only.
    base = ack_count;
    data_in[`SOUTH*16 +: 16] = 16'h0301;
    h[`SOUTH] = 1'b1;
    repeat (2) tick();
    h[`SOUTH] = 1'b0;
    repeat (6) tick();
    check("withdraw_no_ack", ack_count, base);
    check("withdraw_free",   free, 5'b11111);
    request(`LOCAL, 16'h0101, `LOCAL, 4);
    wait_drain(10);

    repeat (2) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
